// File: rtl/pc_sequencer_if.sv
// PC sequencer bus: sequencing commands, interrupt inputs and status.
// The master drives commands; the sequencer (slave) returns pc and status.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int N_IRQ  = 4
);
    logic              increment;
    logic              load;
    logic              call;
    logic              ret;
    logic              reti;
    logic [ADDR_W-1:0] target;
    logic [N_IRQ-1:0]  irq;
    logic              mask_wr;
    logic [N_IRQ-1:0]  mask_data;
    logic              err_clr;
    logic [ADDR_W-1:0] i_addr;
    logic              irq_ack;
    logic [3:0]        irq_id;
    logic              in_isr;
    logic              stack_empty;
    logic              stack_full;
    logic              fault;

    modport master (
        output increment, load, call, ret, reti, target,
        output irq, mask_wr, mask_data, err_clr,
        input  i_addr, irq_ack, irq_id, in_isr,
        input  stack_empty, stack_full, fault
    );

    modport slave (
        input  increment, load, call, ret, reti, target,
        input  irq, mask_wr, mask_data, err_clr,
        output i_addr, irq_ack, irq_id, in_isr,
        output stack_empty, stack_full, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with return stack, vectored
// non-nesting interrupts and a stack-fault trap state.
module pc_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 8,
    parameter int N_IRQ      = 4,
    parameter int RESET_VEC  = 0,
    parameter int VEC_BASE   = 'h0010,
    parameter int VEC_STRIDE = 2,
    parameter int FAULT_VEC  = 'h0008
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, VECTOR, FAULT} state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic [AW:0]       sp;
    logic [ADDR_W-1:0] stack [DEPTH];
    logic [N_IRQ-1:0]  mask;
    logic              isr;
    logic [3:0]        id;
    logic [3:0]        id_d;
    logic              push;
    logic              pop;
    logic              clr;
    logic              isr_set;
    logic              isr_clr;
    logic [ADDR_W-1:0] push_val;
    logic              empty;
    logic              full;
    logic [N_IRQ-1:0]  pend;
    logic [3:0]        lo;
    logic [AW-1:0]     top_idx;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] vec;

    assign empty   = (sp == '0);
    assign full    = (sp == (AW+1)'(DEPTH));
    assign pend    = bus.irq & mask;
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign top     = stack[top_idx];
    assign vec     = ADDR_W'(VEC_BASE + int'(id) * VEC_STRIDE);

    // Lowest-numbered enabled pending request.
    always_comb begin
        lo = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) lo = 4'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_d;
    end

    // Next state plus the pc/stack actions for this edge.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        id_d     = id;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        isr_set  = 1'b0;
        isr_clr  = 1'b0;
        push_val = pc + ADDR_W'(1);
        unique case (state)
            RUN: begin
                if (!isr && !full && |pend) begin
                    push     = 1'b1;
                    push_val = pc;
                    id_d     = lo;
                    isr_set  = 1'b1;
                    state_d  = VECTOR;
                end else if ((bus.reti || bus.ret) && empty) begin
                    clr     = 1'b1;
                    isr_clr = 1'b1;
                    pc_d    = ADDR_W'(FAULT_VEC);
                    state_d = FAULT;
                end else if (bus.reti || bus.ret) begin
                    pop     = 1'b1;
                    pc_d    = top;
                    isr_clr = bus.reti;
                end else if (bus.call && full) begin
                    clr     = 1'b1;
                    isr_clr = 1'b1;
                    pc_d    = ADDR_W'(FAULT_VEC);
                    state_d = FAULT;
                end else if (bus.call) begin
                    push = 1'b1;
                    pc_d = bus.target;
                end else if (bus.load) begin
                    pc_d = bus.target;
                end else if (bus.increment) begin
                    pc_d = pc + ADDR_W'(1);
                end
            end
            VECTOR: begin
                pc_d    = vec;
                state_d = RUN;
            end
            FAULT: begin
                if (bus.load)           pc_d = bus.target;
                else if (bus.increment) pc_d = pc + ADDR_W'(1);
                if (bus.err_clr) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Datapath: pc, return stack, mask, handler flag, latched id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= ADDR_W'(RESET_VEC);
            sp   <= '0;
            mask <= '0;
            isr  <= 1'b0;
            id   <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            pc <= pc_d;
            id <= id_d;
            if (clr) begin
                sp <= '0;
            end else if (push) begin
                stack[sp[AW-1:0]] <= push_val;
                sp <= sp + (AW+1)'(1);
            end else if (pop) begin
                sp <= sp - (AW+1)'(1);
            end
            if (isr_set)      isr <= 1'b1;
            else if (isr_clr) isr <= 1'b0;
            if (bus.mask_wr) mask <= bus.mask_data;
        end
    end

    // Outputs, all derived from registered state.
    always_comb begin
        bus.i_addr      = pc;
        bus.irq_ack     = (state == VECTOR);
        bus.irq_id      = (state == VECTOR) ? id : 4'd0;
        bus.in_isr      = isr;
        bus.stack_empty = empty;
        bus.stack_full  = full;
        bus.fault       = (state == FAULT);
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DEPTH, default 8, return-stack entries (power of 2, >=2); N_IRQ, default 4, interrupt channels (1..16); RESET_VEC, default 0, i_addr after reset; VEC_BASE, default 16'h0010, first interrupt vector; VEC_STRIDE, default 2, vector spacing; FAULT_VEC, default 16'h0008, stack-fault handler address.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk in 1 sole clock, rising edge; rst_n in 1 reset. One clock; reset is asynchronous and active-low.
- increment in 1: pc <- pc+1.
- load in 1: pc <- target.
- call in 1: push pc+1, pc <- target.
- ret in 1: pc <- pop.
- reti in 1: pc <- pop, clear in_isr.
- target in ADDR_W: jump/call destination.
- irq in N_IRQ: level interrupt requests.
- mask_wr in 1: mask <- mask_data.
- mask_data in N_IRQ: new enable mask (1 = enabled).
- err_clr in 1: leave FAULT.
- i_addr out ADDR_W: current pc.
- irq_ack out 1: one-cycle pulse, interrupt accepted.
- irq_id out 4: accepted channel index, valid with irq_ack.
- in_isr out 1: handler active.
- stack_empty out 1; stack_full out 1.
- fault out 1: high in FAULT state.

Function
REQ-003 State machine SHALL be RUN, VECTOR, FAULT.
REQ-004 In RUN, per-edge precedence SHALL be interrupt entry > reti > ret > call > load > increment; lower-precedence commands that cycle are ignored; no command holds pc.
REQ-005 pc arithmetic SHALL wrap modulo 2^ADDR_W (increment and call return address).
REQ-006 Interrupt entry SHALL occur in RUN when in_isr=0, stack not full, and (irq & mask) != 0; lowest set index wins.
REQ-007 Entry edge SHALL push current pc (instruction not executed), latch id, set in_isr, go to VECTOR; pc unchanged.
REQ-008 In VECTOR (exactly one cycle) irq_ack=1, irq_id=latched id, all commands ignored; next edge pc <- VEC_BASE + id*VEC_STRIDE (truncated to ADDR_W), state RUN.
REQ-009 Interrupts SHALL not nest; pending requests with stack full are deferred, not dropped (level-held).
REQ-010 mask_wr SHALL take effect at the edge and SHALL be honoured in every state; new mask affects entry from the following cycle.
REQ-011 Stack is LIFO of DEPTH entries; call with stack_full or ret/reti with stack_empty SHALL enter FAULT: pc <- FAULT_VEC, stack emptied, in_isr cleared, no push/pop performed.
REQ-012 In FAULT, fault=1, interrupts not accepted, increment/load SHALL operate normally, call/ret/reti ignored; err_clr SHALL return to RUN at the next edge (err_clr outside FAULT is ignored).
REQ-013 stack_full/stack_empty SHALL reflect occupancy after each edge (registered, no combinational paths from inputs).
REQ-014 irq_id SHALL be 0 when irq_ack=0.

Reset
REQ-015 rst_n low SHALL asynchronously force: i_addr=RESET_VEC, state RUN, stack empty (stack_empty=1, stack_full=0), mask=0, in_isr=0, irq_ack=0, irq_id=0, fault=0.
REQ-016 Reset mid-VECTOR or mid-FAULT SHALL abandon the operation with no ack pulse after release; first edge after release obeys REQ-004.

Verification
REQ-017 Reset then 3 increment cycles -> i_addr 0,1,2,3; load target=0x1234 -> 0x1234; increment at 0xFFFF -> 0x0000.
REQ-018 call target=0x0100 from pc=0x0020, nested call 0x0200, ret, ret -> i_addr 0x0100, 0x0200, 0x0101, 0x0021; stack_empty=1 at end.
REQ-019 mask=4'b1010, irq=4'b1110 at pc=0x0050 -> one cycle irq_ack=1 irq_id=1, then i_addr=0x0012, in_isr=1; irq held -> no second ack; reti -> i_addr=0x0050, in_isr=0, then ack id=1 again.
REQ-020 DEPTH=8: 8 calls -> stack_full=1; pending enabled irq not acked; 9th call -> fault=1, i_addr=0x0008, stack_empty=1; err_clr -> RUN, irq then acked.
REQ-021 ret at reset (empty) -> fault, i_addr=0x0008; call during FAULT ignored; rst_n pulsed low mid-VECTOR -> i_addr=0, no irq_ack after release.
REQ-022 Same edge irq entry and call asserted -> entry wins, pushed value = pre-call pc, call target not loaded.
